alu_arbiter: RTL

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester front end for a shared external 16-bit ALU.
// A request is accepted in IDLE and its operands are registered. A legal
// opcode then spends ALU_LAT cycles in EXEC while the external ALU settles,
// and the result is captured into RESP. An illegal opcode goes straight to
// RESP with resp_err=1. RESP is held until resp_ready=1.
// Optional build macro ALU_ARB_RR_EN: round-robin arbitration between the two
// requesters. When the macro is undefined, requester 0 has fixed priority.
module alu_arbiter #(
  parameter int ALU_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  input  logic        req1_valid,
  output logic        req0_ready,
  output logic        req1_ready,
  input  logic [15:0] req0_a,
  input  logic [15:0] req0_b,
  input  logic [15:0] req1_a,
  input  logic [15:0] req1_b,
  input  logic [3:0]  req0_op,
  input  logic [3:0]  req1_op,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [3:0]  alu_op,
  input  logic [15:0] alu_s,
  input  logic        alu_ovf,
  input  logic        alu_zero,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic        resp_id,
  output logic [15:0] resp_s,
  output logic        resp_ovf,
  output logic        resp_zero,
  output logic        resp_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] a_q, a_d;
  logic [15:0] b_q, b_d;
  logic [3:0]  op_q, op_d;
  logic        id_q, id_d;
  logic        resp_valid_q, resp_valid_d;
  logic        resp_id_q, resp_id_d;
  logic [15:0] resp_s_q, resp_s_d;
  logic        resp_ovf_q, resp_ovf_d;
  logic        resp_zero_q, resp_zero_d;
  logic        resp_err_q, resp_err_d;

  logic        grant_id;
  logic        accept;
  logic [3:0]  op_sel;

  // Opcode legality: the set the external ALU implements.
  function automatic logic op_legal(input logic [3:0] op);
    case (op)
      4'b0000, 4'b0001, 4'b0010, 4'b0011,
      4'b0100, 4'b0101, 4'b0110, 4'b1000,
      4'b1001, 4'b1010, 4'b1100, 4'b1110: op_legal = 1'b1;
      default:                            op_legal = 1'b0;
    endcase
  endfunction

`ifdef ALU_ARB_RR_EN
  logic prio_q, prio_d;

  // Round-robin: on a tie the requester not granted last time wins.
  always_comb begin
    grant_id = (req0_valid && req1_valid) ? prio_q : req1_valid;
    prio_d   = accept ? ~grant_id : prio_q;
  end

  // Priority pointer; starts favouring requester 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prio_q <= 1'b0;
    else        prio_q <= prio_d;
  end
`else
  // Fixed priority: requester 0 wins whenever it is valid.
  always_comb begin
    grant_id = !req0_valid;
  end
`endif

  // Ready is combinational in IDLE and is forced low while reset is asserted.
  assign accept     = rst_n && (state_q == IDLE) && (req0_valid || req1_valid);
  assign req0_ready = accept && !grant_id;
  assign req1_ready = accept &&  grant_id;
  assign op_sel     = grant_id ? req1_op : req0_op;

  // The ALU sees only registered operands, and only while executing.
  assign alu_a  = (state_q == EXEC) ? a_q  : 16'h0000;
  assign alu_b  = (state_q == EXEC) ? b_q  : 16'h0000;
  assign alu_op = (state_q == EXEC) ? op_q : 4'h0;

  assign resp_valid = resp_valid_q;
  assign resp_id    = resp_id_q;
  assign resp_s     = resp_s_q;
  assign resp_ovf   = resp_ovf_q;
  assign resp_zero  = resp_zero_q;
  assign resp_err   = resp_err_q;

  // Next-state and next-output logic for the IDLE/EXEC/RESP sequencer.
  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    state_d      = state_q;
    cnt_d        = cnt_q;
    a_d          = a_q;
    b_d          = b_q;
    op_d         = op_q;
    id_d         = id_q;
    resp_valid_d = resp_valid_q;
    resp_id_d    = resp_id_q;
    resp_s_d     = resp_s_q;
    resp_ovf_d   = resp_ovf_q;
    resp_zero_d  = resp_zero_q;
    resp_err_d   = resp_err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          a_d  = grant_id ? req1_a : req0_a;
          b_d  = grant_id ? req1_b : req0_b;
          op_d = op_sel;
          id_d = grant_id;
          if (op_legal(op_sel)) begin
            state_d = EXEC;
            cnt_d   = 4'(ALU_LAT);
          end else begin
            // An illegal opcode never reaches the ALU; it is answered next cycle.
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_id_d    = grant_id;
            resp_s_d     = 16'h0000;
            resp_ovf_d   = 1'b0;
            resp_zero_d  = 1'b0;
            resp_err_d   = 1'b1;
          end
        end
      end
      EXEC: begin
        if (cnt_q <= 4'd1) begin
          state_d      = RESP;
          cnt_d        = 4'd0;
          resp_valid_d = 1'b1;
          resp_id_d    = id_q;
          resp_s_d     = alu_s;
          resp_ovf_d   = alu_ovf;
          resp_zero_d  = alu_zero;
          resp_err_d   = 1'b0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_d      = IDLE;
          resp_valid_d = 1'b0;
          resp_id_d    = 1'b0;
          resp_s_d     = 16'h0000;
          resp_ovf_d   = 1'b0;
          resp_zero_d  = 1'b0;
          resp_err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, operand and response registers; reset discards any in-flight op.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      a_q          <= 16'h0000;
      b_q          <= 16'h0000;
      op_q         <= 4'h0;
      id_q         <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= 1'b0;
      resp_s_q     <= 16'h0000;
      resp_ovf_q   <= 1'b0;
      resp_zero_q  <= 1'b0;
      resp_err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      a_q          <= a_d;
      b_q          <= b_d;
      op_q         <= op_d;
      id_q         <= id_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      resp_s_q     <= resp_s_d;
      resp_ovf_q   <= resp_ovf_d;
      resp_zero_q  <= resp_zero_d;
      resp_err_q   <= resp_err_d;
    end
  end

endmodule
